// File: rtl/ritc_capture_sequencer.sv
// RITC capture buffer sequencer: circular write addressing while armed, post-trigger
// window, freeze, and oldest-first replay of the whole buffer over a valid/ready stream.
module ritc_capture_sequencer #(
   parameter int ADDR_BITS = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 arm_i,
   input  logic                 trig_i,
   input  logic [ADDR_BITS-1:0] post_len_i,
   input  logic                 rd_start_i,
   input  logic                 rd_ready_i,
   output logic                 ram_we_o,
   output logic [ADDR_BITS-1:0] ram_waddr_o,
   output logic                 ram_re_o,
   output logic [ADDR_BITS-1:0] ram_raddr_o,
   output logic                 rd_valid_o,
   output logic                 rd_last_o,
   output logic [ADDR_BITS-1:0] trig_addr_o,
   output logic [2:0]           state_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMED  = 3'd1,
      S_POST   = 3'd2,
      S_FROZEN = 3'd3,
      S_READ   = 3'd4
   } state_t;

   // Read count runs 0..DEPTH, so it carries one extra bit.
   localparam logic [ADDR_BITS:0] RD_TOTAL = {1'b1, {ADDR_BITS{1'b0}}};

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [ADDR_BITS-1:0] raddr_q, raddr_d;
   logic [ADDR_BITS-1:0] fill_cnt_q, fill_cnt_d;
   logic [ADDR_BITS-1:0] post_len_q, post_len_d;
   logic [ADDR_BITS-1:0] post_cnt_q, post_cnt_d;
   logic [ADDR_BITS-1:0] trig_addr_q, trig_addr_d;
   logic [ADDR_BITS:0]   rd_cnt_q, rd_cnt_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 we, re, filled, accept;

   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      fill_cnt_d  = fill_cnt_q;
      post_len_d  = post_len_q;
      post_cnt_d  = post_cnt_q;
      trig_addr_d = trig_addr_q;
      rd_cnt_d    = rd_cnt_q;
      rd_valid_d  = rd_valid_q;
      we          = 1'b0;
      re          = 1'b0;
      filled      = (fill_cnt_q == '1);
      accept      = rd_valid_q && rd_ready_i;

      case (state_q)
         S_IDLE: begin
            if (arm_i) begin
               state_d    = S_ARMED;
               post_len_d = post_len_i;
               fill_cnt_d = '0;
            end
         end
         S_ARMED: begin
            we      = 1'b1;
            waddr_d = waddr_q + ADDR_BITS'(1);
            if (!filled) fill_cnt_d = fill_cnt_q + ADDR_BITS'(1);
            // A re-arm restarts the fill and takes precedence over a trigger.
            if (arm_i) begin
               post_len_d = post_len_i;
               fill_cnt_d = '0;
            end else if (trig_i && filled) begin
               trig_addr_d = waddr_q;
               if (post_len_q == '0) begin
                  state_d = S_FROZEN;
               end else begin
                  post_cnt_d = post_len_q;
                  state_d    = S_POST;
               end
            end
         end
         S_POST: begin
            we         = 1'b1;
            waddr_d    = waddr_q + ADDR_BITS'(1);
            post_cnt_d = post_cnt_q - ADDR_BITS'(1);
            if (post_cnt_q == ADDR_BITS'(1)) state_d = S_FROZEN;
         end
         S_FROZEN: begin
            if (arm_i) begin
               state_d    = S_ARMED;
               post_len_d = post_len_i;
               fill_cnt_d = '0;
            end else if (rd_start_i) begin
               state_d    = S_READ;
               raddr_d    = waddr_q;
               rd_cnt_d   = '0;
               rd_valid_d = 1'b0;
            end
         end
         S_READ: begin
            // The RAM holds its output while re is low, so at most one word is in flight.
            re = (rd_cnt_q != RD_TOTAL) && (!rd_valid_q || rd_ready_i);
            if (re) begin
               raddr_d    = raddr_q + ADDR_BITS'(1);
               rd_cnt_d   = rd_cnt_q + (ADDR_BITS+1)'(1);
               rd_valid_d = 1'b1;
            end else if (rd_ready_i) begin
               rd_valid_d = 1'b0;
            end
            if (accept && rd_cnt_q == RD_TOTAL) state_d = S_FROZEN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         waddr_q     <= '0;
         raddr_q     <= '0;
         fill_cnt_q  <= '0;
         post_len_q  <= '0;
         post_cnt_q  <= '0;
         trig_addr_q <= '0;
         rd_cnt_q    <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         fill_cnt_q  <= fill_cnt_d;
         post_len_q  <= post_len_d;
         post_cnt_q  <= post_cnt_d;
         trig_addr_q <= trig_addr_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign ram_we_o    = we;
   assign ram_waddr_o = waddr_q;
   assign ram_re_o    = re;
   assign ram_raddr_o = raddr_q;
   assign rd_valid_o  = rd_valid_q;
   assign rd_last_o   = rd_valid_q && (rd_cnt_q == RD_TOTAL);
   assign trig_addr_o = trig_addr_q;
   assign state_o     = state_q;
   assign done_o      = (state_q == S_FROZEN);

endmodule

// File: doc/ritc_capture_sequencer.md
Name: ritc_capture_sequencer

Overview:
Control sequencer for the RITC sample capture buffer, which holds the delayed A/B/C sample words. It drives write addressing of an external circular sample RAM (2^ADDR_BITS words) while armed. On trigger it finishes a programmable post-trigger window and freezes. It then replays the whole buffer, oldest first, to a readout engine over a valid/ready stream. The block does address and handshake sequencing only; sample data goes straight from the storage taps into the RAM.

Parameters:
ADDR_BITS, 9, RAM address width; DEPTH = 2^ADDR_BITS.

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_n_i  in  1  reset, synchronous, active-low.
arm_i  in  1  single-cycle arm request.
trig_i  in  1  trigger request (level sampled each cycle).
post_len_i  in  ADDR_BITS  post-trigger sample count; latched on arm.
rd_start_i  in  1  single-cycle readout request.
rd_ready_i  in  1  readout consumer ready.
ram_we_o  out  1  RAM write enable.
ram_waddr_o  out  ADDR_BITS  RAM write address.
ram_re_o  out  1  RAM read enable; RAM holds its output while low, 1-cycle read latency.
ram_raddr_o  out  ADDR_BITS  RAM read address.
rd_valid_o  out  1  RAM output word valid to consumer.
rd_last_o  out  1  qualifies final word of a readout (with rd_valid_o).
trig_addr_o  out  ADDR_BITS  RAM address of the trigger sample.
state_o  out  3  IDLE=0, ARMED=1, POST=2, FROZEN=3, READ=4.
done_o  out  1  high in FROZEN.

Behaviour:
- Reset (rst_n_i low at an edge): state IDLE. All outputs 0, including waddr/raddr pointers, fill/post/read counters and trig_addr_o. Reset mid-capture or mid-readout aborts immediately; no drain.
- IDLE: we=0, re=0. arm_i -> ARMED next cycle.
- On arm (accepted in IDLE, ARMED, FROZEN): latch post_len_i; clear fill_cnt. The write pointer is not reset and continues from its current value.
- ARMED: ram_we_o=1 every cycle; ram_waddr_o increments by 1 per cycle, wrapping DEPTH-1 -> 0.
- fill_cnt increments per write and saturates at DEPTH-1. "filled" = fill_cnt==DEPTH-1 (registered value).
- trig_i while ARMED and filled: the current cycle's write is the trigger sample.
  - trig_addr_o <= ram_waddr_o.
  - If latched post_len==0 -> FROZEN.
  - Otherwise post_cnt <= post_len -> POST.
- trig_i while ARMED and not filled is ignored (not queued).
- arm_i in ARMED restarts the fill: fill_cnt cleared, post_len relatched.
- POST: writes continue. post_cnt decrements per write; the write at which post_cnt==1 is the last, then -> FROZEN. Exactly post_len writes follow the trigger sample.
- POST ignores trig_i and arm_i.
- FROZEN: we=0, done_o=1. ram_waddr_o holds the next slot, which is the oldest sample.
  - rd_start_i -> READ: ram_raddr_o <= ram_waddr_o, rd_cnt <= 0.
  - arm_i -> ARMED.
  - arm_i and rd_start_i in the same cycle: arm wins.
- READ: ram_re_o = (rd_cnt < DEPTH) && (!rd_valid_o || rd_ready_i).
  - Each issued read increments ram_raddr_o (wrapping) and rd_cnt.
  - rd_valid_o is registered: set the cycle after an issued read; cleared when accepted (rd_ready_i) with no new read issued.
  - A word is accepted when rd_valid_o && rd_ready_i. With continuous ready, throughput is 1 word/cycle. No word is lost or duplicated under arbitrary ready stalls.
  - rd_last_o = rd_valid_o && word index == DEPTH-1.
  - Exactly DEPTH words are delivered. After the last is accepted -> FROZEN; the buffer is unchanged and may be re-read.
  - arm_i, trig_i and rd_start_i are ignored in READ.
- Trigger word position in the readout stream = DEPTH-1-post_len (0-based).
- trig_addr_o is held until the next accepted trigger or reset.

Test Plan:
- ADDR_BITS=4, post_len=5. Arm, trig_i held high from arm+3: trigger is not accepted until fill_cnt=15. Then exactly 5 more writes, FROZEN, done_o=1; trig_addr_o = address written at the acceptance cycle.
- From that freeze, rd_start with rd_ready_i=1: 16 words on 16 consecutive cycles, raddr starting at frozen waddr. rd_last_o only on word 15; the word at index 10 comes from trig_addr_o.
- Same readout with rd_ready_i toggling at random: still exactly 16 accepted words in address order, no duplicates; rd_valid_o never drops while unaccepted.
- post_len=0: FROZEN on the cycle after the trigger; the trigger sample is the last word (index 15) with rd_last_o.
- Write-pointer wrap: arm with waddr=14, run 20 cycles; waddr sequence 14,15,0,1,... Then re-arm in FROZEN with simultaneous rd_start_i: goes to ARMED, no readout issued.
- Reset asserted mid-READ and mid-POST: next cycle state_o=0, rd_valid_o=0, ram_we_o=0, ram_re_o=0, trig_addr_o=0.
